// File: rtl/fix_pkg.sv
// fix_pkg: shared types and constants for the FIX line packer.
//   state_t        - packer FSM state encoding
//   BYTES_PER_LINE - byte lanes in a default-width (256-bit) line
//   SOH            - FIX field delimiter byte
//   lanes_for()    - byte lanes in a line of arbitrary width
package fix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,    // no partial line held
        ST_FILL,    // partial line held
        ST_FULL     // every line slot occupied
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 256;
    localparam int unsigned BYTES_PER_LINE     = DEFAULT_DATA_WIDTH / 8;
    localparam logic [7:0]  SOH                = 8'h01;

    function automatic int unsigned lanes_for(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/fix_byte_lane_sel.sv
// fix_byte_lane_sel: decodes the current byte position within a line into a
// one-hot lane enable.
//   pos_i     - byte position, 0..LANES-1
//   lane_en_o - one-hot lane enable, bit k set when pos_i == k
module fix_byte_lane_sel #(
    parameter int unsigned LANES = 32,
    parameter int unsigned POS_W = 5
) (
    input  logic [POS_W-1:0] pos_i,
    output logic [LANES-1:0] lane_en_o
);

    always_comb begin
        lane_en_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_en_o[k] = (pos_i == POS_W'(k));
        end
    end

endmodule

// File: rtl/fix_line_packer.sv
// fix_line_packer: packs a FIX byte stream into fixed-width lines for a line
// RAM, tracking line occupancy until the consumer releases each line.
// Optional feature macro: FIX_CKSUM_EN (adds cksum_o / cksum_valid_o).
//   clk, rst         - clock; asynchronous active-low reset
//   byte_valid_i     - byte_i is valid
//   byte_i           - message byte
//   byte_last_i      - final byte of a message
//   ready_o          - byte accepted this cycle when byte_valid_i is high
//   release_i        - consumer frees one line
//   write_o          - one-cycle line-write strobe
//   write_index_o    - line index of the write
//   write_data_o     - packed line; MSB is the end-of-message flag
//   count_o          - occupied lines, including a write in flight
//   underflow_o      - sticky: release_i seen with count_o == 0
//   cksum_o          - (FIX_CKSUM_EN) message byte sum mod 256, last byte excluded
//   cksum_valid_o    - (FIX_CKSUM_EN) cksum_o valid, aligned to final write_o
module fix_line_packer
    import fix_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_last_i,
    output logic                  ready_o,
    input  logic                  release_i,
    output logic                  write_o,
    output logic [ADDR_WIDTH-1:0] write_index_o,
    output logic [DATA_WIDTH:0]   write_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  underflow_o
`ifdef FIX_CKSUM_EN
    ,
    output logic [7:0]            cksum_o,
    output logic                  cksum_valid_o
`endif
);

    localparam int unsigned LANES = lanes_for(DATA_WIDTH);
    localparam int unsigned POS_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                 state;
    logic [POS_W-1:0]       pos;
    logic [LANES-1:0]       lane_en;
    logic [DATA_WIDTH-1:0]  line_q;
    logic [DATA_WIDTH-1:0]  line_next;
    logic [ADDR_WIDTH-1:0]  next_idx;
    logic [ADDR_WIDTH:0]    count_next;
    logic                   accept;
    logic                   completing;
    logic                   release_eff;
    logic                   partial_next;

    fix_byte_lane_sel #(
        .LANES (LANES),
        .POS_W (POS_W)
    ) u_lane_sel (
        .pos_i     (pos),
        .lane_en_o (lane_en)
    );

    // FULL is entered exactly when count reaches DEPTH, so the state register
    // alone gives a registered-only ready.
    assign ready_o    = (state != ST_FULL);
    assign accept     = byte_valid_i && ready_o;
    assign completing = accept && (byte_last_i || (pos == POS_W'(LANES - 1)));

    // A release with nothing occupied frees nothing; it only raises underflow.
    assign release_eff = release_i && (count_o != '0);

    always_comb begin
        line_next = line_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_en[k]) begin
                line_next[8*k +: 8] = byte_i;
            end
        end
    end

    always_comb begin
        count_next = count_o;
        if (completing && !release_eff) begin
            count_next = count_o + (ADDR_WIDTH+1)'(1);
        end else if (!completing && release_eff) begin
            count_next = count_o - (ADDR_WIDTH+1)'(1);
        end
    end

    assign partial_next = !completing && (accept || (pos != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            pos           <= '0;
            line_q        <= '0;
            next_idx      <= '0;
            write_o       <= 1'b0;
            write_index_o <= '0;
            write_data_o  <= '0;
            count_o       <= '0;
            underflow_o   <= 1'b0;
        end else begin
            write_o <= completing;
            count_o <= count_next;
            if (release_i && (count_o == '0)) begin
                underflow_o <= 1'b1;
            end
            if (completing) begin
                write_data_o  <= {byte_last_i, line_next};
                write_index_o <= next_idx;
                next_idx      <= next_idx + ADDR_WIDTH'(1);
                line_q        <= '0;
                pos           <= '0;
            end else if (accept) begin
                line_q <= line_next;
                pos    <= pos + POS_W'(1);
            end
            if (count_next == DEPTH) begin
                state <= ST_FULL;
            end else if (partial_next) begin
                state <= ST_FILL;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

`ifdef FIX_CKSUM_EN
    logic [7:0] cksum_acc;

    // The last byte always completes a line, so the checksum strobe lines up
    // with the message's final write_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cksum_acc     <= '0;
            cksum_o       <= '0;
            cksum_valid_o <= 1'b0;
        end else begin
            cksum_valid_o <= 1'b0;
            if (accept) begin
                if (byte_last_i) begin
                    cksum_o       <= cksum_acc;
                    cksum_valid_o <= 1'b1;
                    cksum_acc     <= '0;
                end else begin
                    cksum_acc <= cksum_acc + byte_i;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fix_line_packer.sv
module tb_fix_line_packer;

    localparam int DW = 256;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_i = '0;
    logic          byte_last_i = 1'b0;
    logic          ready_o;
    logic          release_i = 1'b0;
    logic          write_o;
    logic [AW-1:0] write_index_o;
    logic [DW:0]   write_data_o;
    logic [AW:0]   count_o;
    logic          underflow_o;
`ifdef FIX_CKSUM_EN
    logic [7:0]    cksum_o;
    logic          cksum_valid_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    int            wr_cnt = 0;
    logic [AW-1:0] last_idx = '0;
    logic [DW:0]   last_data = '0;
    logic [7:0]    last_ck = '0;

    fix_line_packer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .byte_valid_i  (byte_valid_i),
        .byte_i        (byte_i),
        .byte_last_i   (byte_last_i),
        .ready_o       (ready_o),
        .release_i     (release_i),
        .write_o       (write_o),
        .write_index_o (write_index_o),
        .write_data_o  (write_data_o),
        .count_o       (count_o),
        .underflow_o   (underflow_o)
`ifdef FIX_CKSUM_EN
        ,
        .cksum_o       (cksum_o),
        .cksum_valid_o (cksum_valid_o)
`endif
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (write_o) begin
            wr_cnt    = wr_cnt + 1;
            last_idx  = write_index_o;
            last_data = write_data_o;
        end
`ifdef FIX_CKSUM_EN
        if (cksum_valid_o) last_ck = cksum_o;
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        byte_valid_i = 1'b0;
        byte_last_i = 1'b0;
        release_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // Presents one byte and holds it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b, input logic l, output logic ok);
        int n;
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i = b;
        byte_last_i = l;
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = ready_o;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        tests_run++;
        if ({write_o, write_index_o, count_o, underflow_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got w=%0b idx=%0d cnt=%0d uf=%0b expected all 0",
                     write_o, write_index_o, count_o, underflow_o);
        end
        tests_run++;
        if (write_data_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0", write_data_o);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", ready_o);
        end
    endtask

    task automatic test_full_line;
        logic ok, ok_all;
        int w0;
        logic [DW:0] exp;
        exp = {1'b1, 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100};
        w0 = wr_cnt;
        ok_all = 1'b1;
        for (int k = 0; k < 32; k++) begin
            send_byte(8'(k), k == 31, ok);
            ok_all &= ok;
        end
        idle(2);
        tests_run++;
        if (!ok_all) begin
            tests_failed++;
            $display("FAIL full_line_accept: got stalled byte expected all accepted");
        end
        tests_run++;
        if (wr_cnt - w0 !== 1) begin
            tests_failed++;
            $display("FAIL full_line_writes: got %0d expected 1", wr_cnt - w0);
        end
        tests_run++;
        if (last_idx !== 5'd0) begin
            tests_failed++;
            $display("FAIL full_line_index: got %0d expected 0", last_idx);
        end
        tests_run++;
        if (last_data !== exp) begin
            tests_failed++;
            $display("FAIL full_line_data: got %h expected %h", last_data, exp);
        end
        tests_run++;
        if (count_o !== 6'd1) begin
            tests_failed++;
            $display("FAIL full_line_count: got %0d expected 1", count_o);
        end
`ifdef FIX_CKSUM_EN
        tests_run++;
        if (last_ck !== 8'hD1) begin
            tests_failed++;
            $display("FAIL full_line_cksum: got %h expected d1", last_ck);
        end
`endif
    endtask

    task automatic test_short_msg;
        logic ok, ok_all;
        int w0;
        logic [DW:0] exp;
        exp = '0;
        exp[DW] = 1'b1;
        exp[23:0] = 24'h463D38;
        w0 = wr_cnt;
        ok_all = 1'b1;
        send_byte(8'h38, 1'b0, ok); ok_all &= ok;
        send_byte(8'h3D, 1'b0, ok); ok_all &= ok;
        send_byte(8'h46, 1'b1, ok); ok_all &= ok;
        idle(2);
        tests_run++;
        if (!ok_all || wr_cnt - w0 !== 1) begin
            tests_failed++;
            $display("FAIL short_writes: got %0d (accept=%0b) expected 1", wr_cnt - w0, ok_all);
        end
        tests_run++;
        if (last_idx !== 5'd1) begin
            tests_failed++;
            $display("FAIL short_index: got %0d expected 1", last_idx);
        end
        tests_run++;
        if (last_data !== exp) begin
            tests_failed++;
            $display("FAIL short_data: got %h expected %h", last_data, exp);
        end
        tests_run++;
        if (count_o !== 6'd2) begin
            tests_failed++;
            $display("FAIL short_count: got %0d expected 2", count_o);
        end
`ifdef FIX_CKSUM_EN
        tests_run++;
        if (last_ck !== 8'h75) begin
            tests_failed++;
            $display("FAIL short_cksum: got %h expected 75", last_ck);
        end
`endif
    endtask

    task automatic test_fill_to_full;
        logic ok, ok_all, stall_ok;
        int w0;
        do_reset();
        w0 = wr_cnt;
        ok_all = 1'b1;
        for (int l = 0; l < 32; l++) begin
            for (int k = 0; k < 32; k++) begin
                send_byte(8'(l), 1'b0, ok);
                ok_all &= ok;
            end
        end
        idle(2);
        tests_run++;
        if (!ok_all || wr_cnt - w0 !== 32) begin
            tests_failed++;
            $display("FAIL fill_writes: got %0d (accept=%0b) expected 32", wr_cnt - w0, ok_all);
        end
        tests_run++;
        if (last_idx !== 5'd31 || last_data !== {1'b0, {32{8'h1F}}}) begin
            tests_failed++;
            $display("FAIL fill_last_line: got idx=%0d data=%h expected idx=31 data=%h",
                     last_idx, last_data, {1'b0, {32{8'h1F}}});
        end
        tests_run++;
        if (count_o !== 6'd32 || ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: got cnt=%0d ready=%b expected cnt=32 ready=0", count_o, ready_o);
        end
        // 33rd line stalls while full.
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i = 8'hA5;
        byte_last_i = 1'b0;
        w0 = wr_cnt;
        stall_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ready_o !== 1'b0) stall_ok = 1'b0;
        end
        tests_run++;
        if (!stall_ok || wr_cnt != w0 || count_o !== 6'd32) begin
            tests_failed++;
            $display("FAIL fill_stall: got ready_ok=%0b writes=%0d cnt=%0d expected 1 0 32",
                     stall_ok, wr_cnt - w0, count_o);
        end
        byte_valid_i = 1'b0;
        release_i = 1'b1;
        @(posedge clk);
        #1;
        release_i = 1'b0;
        tests_run++;
        if (count_o !== 6'd31 || ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_release: got cnt=%0d ready=%b expected cnt=31 ready=1", count_o, ready_o);
        end
        ok_all = 1'b1;
        for (int k = 0; k < 32; k++) begin
            send_byte(8'hA5, 1'b0, ok);
            ok_all &= ok;
        end
        idle(2);
        tests_run++;
        if (!ok_all || last_idx !== 5'd0 || last_data !== {1'b0, {32{8'hA5}}}) begin
            tests_failed++;
            $display("FAIL fill_wrap: got idx=%0d data=%h accept=%0b expected idx=0 data=%h",
                     last_idx, last_data, ok_all, {1'b0, {32{8'hA5}}});
        end
        tests_run++;
        if (count_o !== 6'd32) begin
            tests_failed++;
            $display("FAIL fill_wrap_count: got %0d expected 32", count_o);
        end
    endtask

    task automatic test_release_same_cycle;
        logic ok, ok_all;
        do_reset();
        ok_all = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_byte(8'h50 + 8'(k), 1'b1, ok);
            ok_all &= ok;
        end
        idle(1);
        tests_run++;
        if (!ok_all || count_o !== 6'd5) begin
            tests_failed++;
            $display("FAIL same_cycle_pre: got %0d expected 5", count_o);
        end
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i = 8'h77;
        byte_last_i = 1'b1;
        release_i = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        byte_last_i = 1'b0;
        release_i = 1'b0;
        idle(2);
        tests_run++;
        if (count_o !== 6'd5) begin
            tests_failed++;
            $display("FAIL same_cycle_count: got %0d expected 5", count_o);
        end
        tests_run++;
        if (last_idx !== 5'd5) begin
            tests_failed++;
            $display("FAIL same_cycle_index: got %0d expected 5", last_idx);
        end
    endtask

    task automatic test_reset_mid_line;
        logic ok, ok_all;
        int w0;
        logic [DW:0] exp;
        exp = '0;
        exp[DW] = 1'b1;
        exp[15:0] = 16'hCDAB;
        w0 = wr_cnt;
        ok_all = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send_byte(8'h10 + 8'(k), 1'b0, ok);
            ok_all &= ok;
        end
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (count_o !== '0 || write_data_o !== '0 || write_index_o !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got cnt=%0d idx=%0d data=%h expected all 0",
                     count_o, write_index_o, write_data_o);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        tests_run++;
        if (!ok_all || wr_cnt != w0) begin
            tests_failed++;
            $display("FAIL midline_nowrite: got %0d writes expected 0", wr_cnt - w0);
        end
        send_byte(8'hAB, 1'b0, ok);
        send_byte(8'hCD, 1'b1, ok);
        idle(2);
        tests_run++;
        if (last_idx !== 5'd0 || last_data !== exp) begin
            tests_failed++;
            $display("FAIL midline_next: got idx=%0d data=%h expected idx=0 data=%h",
                     last_idx, last_data, exp);
        end
    endtask

    task automatic test_underflow;
        do_reset();
        @(negedge clk);
        release_i = 1'b1;
        @(posedge clk);
        #1;
        release_i = 1'b0;
        idle(1);
        tests_run++;
        if (underflow_o !== 1'b1 || count_o !== '0) begin
            tests_failed++;
            $display("FAIL underflow_set: got uf=%b cnt=%0d expected uf=1 cnt=0", underflow_o, count_o);
        end
        idle(5);
        tests_run++;
        if (underflow_o !== 1'b1 || ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow_sticky: got uf=%b ready=%b expected 1 1", underflow_o, ready_o);
        end
        do_reset();
        tests_run++;
        if (underflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_clear: got %b expected 0", underflow_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_short_msg();
        test_fill_to_full();
        test_release_same_cycle();
        test_reset_mid_line();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fix_line_packer.md
FIX_LINE_PACKER -- requirements
Module: fix_line_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 256, SHALL set line width in bits; it is a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set line index width; DEPTH = 2^ADDR_WIDTH lines.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 byte_valid_i  input  1  SHALL mark byte_i valid.
REQ-006 byte_i  input  8  SHALL carry one FIX message byte.
REQ-007 byte_last_i  input  1  SHALL mark the final byte of a message (qualified by byte_valid_i).
REQ-008 ready_o  output  1  SHALL indicate a byte is accepted this cycle when byte_valid_i is high.
REQ-009 release_i  input  1  SHALL free one line after the downstream consumer has read it.
REQ-010 write_o  output  1  SHALL be the line-write strobe to the line RAM.
REQ-011 write_index_o  output  ADDR_WIDTH  SHALL be the line index for the write.
REQ-012 write_data_o  output  DATA_WIDTH+1  SHALL carry the packed line; bit DATA_WIDTH is the end-of-message flag.
REQ-013 count_o  output  ADDR_WIDTH+1  SHALL report occupied lines, including any write in flight.
REQ-014 underflow_o  output  1  SHALL be a sticky flag for release_i with count_o == 0.

Function
REQ-015 Accept occurs on a cycle with byte_valid_i && ready_o; byte k of a line (k = 0..DATA_WIDTH/8-1) SHALL go to bits [8k+7:8k].
REQ-016 FSM states: IDLE (no partial line), FILL (partial line held), FULL (count_o == DEPTH).
REQ-017 IDLE->FILL on accept of a non-completing byte; FILL->IDLE on a completing accept; any state->FULL when count_o reaches DEPTH; FULL->IDLE/FILL on release_i.
REQ-018 A completing accept is the byte in position DATA_WIDTH/8-1 or any byte with byte_last_i.
REQ-019 write_o SHALL pulse for exactly one cycle, the cycle after a completing accept.
REQ-020 Unused byte lanes SHALL be zero; bit DATA_WIDTH SHALL equal byte_last_i of the completing byte.
REQ-021 write_index_o SHALL start at 0 and increment modulo DEPTH after each write, wrapping from DEPTH-1 to 0.
REQ-022 ready_o SHALL be low iff count_o == DEPTH; it SHALL be combinational from registers only.
REQ-023 count_o SHALL increment on a completing accept, decrement on release_i, and stay unchanged when both occur in the same cycle.
REQ-024 release_i at count_o == 0 SHALL leave count_o at 0 and set underflow_o.
REQ-025 A byte_last_i byte arriving in position DATA_WIDTH/8-1 SHALL produce a single line with the flag set, not an extra empty line.

Reset
REQ-026 Asserting rst SHALL immediately clear all outputs: write_o=0, write_index_o=0, write_data_o=0, count_o=0, underflow_o=0, ready_o=1 after release.
REQ-027 Reset mid-line SHALL discard the partial line and return the FSM to IDLE; no write SHALL issue for it.

Configuration
REQ-028 Macro FIX_CKSUM_EN defined: outputs cksum_o[7:0] and cksum_valid_o SHALL exist; cksum_o is the sum modulo 256 of all message bytes, excluding the byte_last_i byte; it SHALL be presented with a one-cycle cksum_valid_o aligned to that message's final write_o.
REQ-029 Macro FIX_CKSUM_EN undefined: these ports and the accumulator SHALL be absent, with no other behaviour change.

Structure
REQ-030 Package fix_pkg SHALL hold the FSM state enum, the BYTES_PER_LINE constant and the SOH constant (8'h01).
REQ-031 Sub-module fix_byte_lane_sel SHALL decode the byte position into a DATA_WIDTH/8-bit lane-enable one-hot.

Verification
REQ-032 Reset, then 32 bytes 8'h00..8'h1F with the last one flagged -> one write_o, index 0, data 256'h1F1E..0100 with flag 1.
REQ-033 3-byte message "8=F" with last on 'F' -> write_data_o = {1'b1, zeros, 24'h463D38}; with FIX_CKSUM_EN, cksum_o = 8'h75.
REQ-034 33 full lines with no release -> ready_o low after the 32nd write; the 33rd byte stream stalls; one release_i -> ready_o high, next write index 0.
REQ-035 release_i on the same cycle as a completing accept at count 5 -> count_o stays 5.
REQ-036 release_i at count 0 -> underflow_o = 1 and held until reset.
REQ-037 rst asserted after 10 bytes of a line -> no write; the next message writes at index 0 starting at byte lane 0.
